// File: rtl/sprite_position.sv
// sprite_position
//   Holds and animates the single sprite's on-screen position.
//   Serial bits from the SPI receiver are collected into per-axis shadow
//   registers; once per frame (frame_tick) a three-state FSM either commits a
//   host-written shadow value or advances the sprite by its velocity,
//   reflecting off the visible-area edges. X is updated one cycle before Y.
//
// Ports
//   clk, reset      : system clock, synchronous active-high reset
//   shift_x/shift_y : one-cycle pulse, shift spi_mosi_sync into x/y shadow
//   spi_mosi_sync   : synchronised SPI data bit
//   frame_tick      : one-cycle pulse at start of vblank
//   move_en         : enable autonomous motion
//   speed[1:0]      : per-frame step minus one (step 1..4)
//   sprite_x/_y     : live position (left / top edge)
//   dir_x/dir_y     : 1 = right/down, 0 = left/up
//   bounce          : one-cycle pulse after an axis reflects
//   busy            : FSM not IDLE
module sprite_position #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned SPRITE_W  = 48,
    parameter int unsigned SPRITE_H  = 48,
    parameter logic [9:0]  X_DEFAULT = 10'd296,
    parameter logic [9:0]  Y_DEFAULT = 10'd216
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shift_x,
    input  logic       shift_y,
    input  logic       spi_mosi_sync,
    input  logic       frame_tick,
    input  logic       move_en,
    input  logic [1:0] speed,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       bounce,
    output logic       busy
);

    localparam logic [10:0] XMAX = 11'(H_ACTIVE - SPRITE_W);
    localparam logic [10:0] YMAX = 11'(V_ACTIVE - SPRITE_H);

    typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y} state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
        logic       bnc;
    } step_t;

    state_t     state_q, state_d;
    logic [9:0] x_sh_q, x_sh_d, y_sh_q, y_sh_d;
    logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic       dirty_x_q, dirty_x_d, dirty_y_q, dirty_y_d;
    logic       bounce_q, bounce_d;
    step_t      nx, ny;

    // One motion step on one axis, done in 11 bits so pos+step cannot wrap.
    // A committed position beyond the limit is clamped back by the >= test.
    function automatic step_t move(input logic [9:0] pos, input logic dir,
                                   input logic [1:0] spd, input logic [10:0] lim);
        step_t       r;
        logic [10:0] s, p, sum;
        s     = {9'd0, spd} + 11'd1;
        p     = {1'b0, pos};
        sum   = p + s;
        r.pos = pos;
        r.dir = dir;
        r.bnc = 1'b0;
        if (dir) begin
            if (sum >= lim) begin
                r.pos = lim[9:0];
                r.dir = 1'b0;
                r.bnc = 1'b1;
            end else begin
                r.pos = sum[9:0];
            end
        end else begin
            if (p <= s) begin
                r.pos = 10'd0;
                r.dir = 1'b1;
                r.bnc = 1'b1;
            end else begin
                r.pos = 10'(p - s);
            end
        end
        return r;
    endfunction

    assign nx = move(pos_x_q, dir_x_q, speed, XMAX);
    assign ny = move(pos_y_q, dir_y_q, speed, YMAX);

    always_comb begin
        state_d   = state_q;
        x_sh_d    = x_sh_q;
        y_sh_d    = y_sh_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        dirty_x_d = dirty_x_q;
        dirty_y_d = dirty_y_q;
        bounce_d  = 1'b0;

        unique case (state_q)
            IDLE: if (frame_tick) state_d = UPD_X;
            UPD_X: begin
                state_d = UPD_Y;
                if (dirty_x_q) begin
                    pos_x_d   = x_sh_q;
                    dirty_x_d = 1'b0;
                end else if (move_en) begin
                    pos_x_d  = nx.pos;
                    dir_x_d  = nx.dir;
                    bounce_d = nx.bnc;
                end
            end
            UPD_Y: begin
                state_d = IDLE;
                if (dirty_y_q) begin
                    pos_y_d   = y_sh_q;
                    dirty_y_d = 1'b0;
                end else if (move_en) begin
                    pos_y_d  = ny.pos;
                    dir_y_d  = ny.dir;
                    bounce_d = ny.bnc;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shifts come last so a set in the commit cycle wins over the clear;
        // the commit above already used the pre-shift shadow value.
        if (shift_x) begin
            x_sh_d    = {x_sh_q[8:0], spi_mosi_sync};
            dirty_x_d = 1'b1;
        end
        if (shift_y) begin
            y_sh_d    = {y_sh_q[8:0], spi_mosi_sync};
            dirty_y_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            x_sh_q    <= X_DEFAULT;
            y_sh_q    <= Y_DEFAULT;
            pos_x_q   <= X_DEFAULT;
            pos_y_q   <= Y_DEFAULT;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            dirty_x_q <= 1'b0;
            dirty_y_q <= 1'b0;
            bounce_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_sh_q    <= x_sh_d;
            y_sh_q    <= y_sh_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            dirty_x_q <= dirty_x_d;
            dirty_y_q <= dirty_y_d;
            bounce_q  <= bounce_d;
        end
    end

    assign sprite_x = pos_x_q;
    assign sprite_y = pos_y_q;
    assign dir_x    = dir_x_q;
    assign dir_y    = dir_y_q;
    assign bounce   = bounce_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_position.sv
module tb_sprite_position;

    logic       clk = 1'b0;
    logic       reset, shift_x, shift_y, spi_mosi_sync, frame_tick, move_en;
    logic [1:0] speed;
    logic [9:0] sprite_x, sprite_y;
    logic       dir_x, dir_y, bounce, busy;

    int checks = 0;
    int failures = 0;
    int nbounce = 0;

    // values captured around one frame update
    logic       b1, b2, b3, b4, bo2, bo3, dx2, dy3;
    logic [9:0] x2, y3;

    sprite_position dut (
        .clk(clk), .reset(reset), .shift_x(shift_x), .shift_y(shift_y),
        .spi_mosi_sync(spi_mosi_sync), .frame_tick(frame_tick),
        .move_en(move_en), .speed(speed), .sprite_x(sprite_x),
        .sprite_y(sprite_y), .dir_x(dir_x), .dir_y(dir_y),
        .bounce(bounce), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bounce === 1'b1) nbounce++;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic shift_word(input bit is_y, input logic [15:0] v);
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            shift_x = !is_y;
            shift_y = is_y;
            spi_mosi_sync = v[i];
            @(negedge clk);
            shift_x = 1'b0;
            shift_y = 1'b0;
        end
    endtask

    // Tick in cycle T; col=1 also pulses shift_x (bit 1) and a second tick at T+1.
    task automatic frame(input bit col);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = col; shift_x = col; spi_mosi_sync = col; b1 = busy;
        @(negedge clk); frame_tick = 1'b0; shift_x = 1'b0;
        x2 = sprite_x; bo2 = bounce; b2 = busy; dx2 = dir_x;
        @(negedge clk); y3 = sprite_y; bo3 = bounce; b3 = busy; dy3 = dir_y;
        @(negedge clk); b4 = busy;
    endtask

    initial begin
        int nb0;
        reset = 1'b1; shift_x = 0; shift_y = 0; spi_mosi_sync = 0;
        frame_tick = 0; move_en = 0; speed = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_x", 16'(sprite_x), 16'd296);
        chk("rst_y", 16'(sprite_y), 16'd216);
        chk("rst_dirx", 16'(dir_x), 16'd1);
        chk("rst_diry", 16'(dir_y), 16'd1);
        chk("rst_bounce", 16'(bounce), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);

        // host write x=100 while y keeps moving by 4
        move_en = 1'b1; speed = 2'd3;
        shift_word(1'b0, 16'h0064);
        frame(1'b0);
        chk("wr_busy1", 16'(b1), 16'd1);
        chk("wr_busy2", 16'(b2), 16'd1);
        chk("wr_busy3", 16'(b3), 16'd0);
        chk("wr_x", 16'(x2), 16'd100);
        chk("wr_y", 16'(y3), 16'd220);
        chk("wr_bnc", 16'({bo2, bo3}), 16'd0);

        // right bounce
        shift_word(1'b0, 16'd590);
        frame(1'b0);
        chk("rb_commit", 16'(x2), 16'd590);
        chk("rb_y0", 16'(y3), 16'd224);
        frame(1'b0);
        chk("rb_x", 16'(x2), 16'd592);
        chk("rb_dir", 16'(dx2), 16'd0);
        chk("rb_bnc2", 16'(bo2), 16'd1);
        chk("rb_bnc3", 16'(bo3), 16'd0);
        chk("rb_y1", 16'(y3), 16'd228);
        frame(1'b0);
        chk("rb_back", 16'(x2), 16'd588);
        chk("rb_y2", 16'(y3), 16'd232);

        // bottom bounce: clamp 434 -> 432
        shift_word(1'b1, 16'd430);
        frame(1'b0);
        chk("bb_commit", 16'(y3), 16'd430);
        chk("bb_x0", 16'(x2), 16'd584);
        frame(1'b0);
        chk("bb_x1", 16'(x2), 16'd580);
        chk("bb_y", 16'(y3), 16'd432);
        chk("bb_dir", 16'(dy3), 16'd0);
        chk("bb_bnc", 16'({bo2, bo3}), 16'd1);

        // top bounce from y=2 moving up
        shift_word(1'b1, 16'd2);
        frame(1'b0);
        chk("tb_commit", 16'(y3), 16'd2);
        chk("tb_x0", 16'(x2), 16'd576);
        frame(1'b0);
        chk("tb_x1", 16'(x2), 16'd572);
        chk("tb_y", 16'(y3), 16'd0);
        chk("tb_dir", 16'(dy3), 16'd1);
        chk("tb_bnc", 16'({bo2, bo3}), 16'd1);

        // collision: shift during UPD_X plus an ignored second tick
        move_en = 1'b0;
        shift_word(1'b0, 16'd100);
        frame(1'b1);
        chk("col_x", 16'(x2), 16'd100);
        chk("col_busy3", 16'(b3), 16'd0);
        chk("col_busy4", 16'(b4), 16'd0);
        frame(1'b0);
        chk("col_next", 16'(x2), 16'd201);

        // no motion, no writes: 10 frames stay put
        nb0 = nbounce;
        for (int i = 0; i < 10; i++) frame(1'b0);
        chk("idle_x", 16'(sprite_x), 16'd201);
        chk("idle_y", 16'(sprite_y), 16'd0);
        chk("idle_dir", 16'({dir_x, dir_y}), 16'b01);
        chk("idle_bnc", 16'(nbounce - nb0), 16'd0);

        // reset in the middle of an update
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mid_rst_x", 16'(sprite_x), 16'd296);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        chk("mid_rst_idle", 16'(busy), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
